// File: rtl/switch_input_buffer.sv
// rtl/switch_input_buffer.sv - per-input-port flit FIFO with busy/stall handshake and framing check
`ifndef FTYPEWD
`define FTYPEWD 3
`endif

module switch_input_buffer #(
  parameter int FLIT_WIDTH = 80,
  parameter int DEPTH      = 4,
  parameter int N_OUT      = 3,
  parameter int SLACK      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] FLIT_in,
  input  logic                  VALID_in,
  output logic                  BUSY_out,
  output logic [FLIT_WIDTH-1:0] FLIT_out,
  output logic                  VALID_out,
  input  logic [N_OUT-1:0]      NACK_in,
  output logic                  overflow_err,
  output logic                  proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [`FTYPEWD-1:0] T_HEAD = `FTYPEWD'(1);
  localparam logic [`FTYPEWD-1:0] T_PAYL = `FTYPEWD'(2);
  localparam logic [`FTYPEWD-1:0] T_TAIL = `FTYPEWD'(3);
  localparam logic [`FTYPEWD-1:0] T_SING = `FTYPEWD'(4);

  typedef enum logic {S_IDLE, S_IN_PKT} state_t;

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count, count_next;
  logic                  push, pop;
  logic [`FTYPEWD-1:0]   ftype;
  state_t                state, state_next;
  logic                  frame_viol;

  assign VALID_out  = (count != '0);
  assign FLIT_out   = mem[rd_ptr];
  assign pop        = VALID_out & ~|NACK_in;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push       = VALID_in & ((count < CW'(DEPTH)) | pop);
  assign count_next = count + CW'(push) - CW'(pop);
  assign ftype      = FLIT_in[`FTYPEWD-1:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= FLIT_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      BUSY_out     <= 1'b0;
      overflow_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      count        <= count_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      BUSY_out     <= (count_next >= CW'(DEPTH - SLACK));
      overflow_err <= overflow_err | (VALID_in & ~push);
      proto_err    <= proto_err | frame_viol;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (push) begin
      case (ftype)
        T_HEAD:  state_next = S_IN_PKT;
        T_PAYL:  state_next = state;
        T_TAIL:  state_next = S_IDLE;
        T_SING:  state_next = S_IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    frame_viol = 1'b0;
    if (push) begin
      case (ftype)
        T_HEAD:  frame_viol = (state == S_IN_PKT);
        T_PAYL:  frame_viol = (state == S_IDLE);
        T_TAIL:  frame_viol = (state == S_IDLE);
        T_SING:  frame_viol = (state == S_IN_PKT);
        default: frame_viol = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_input_buffer.sv
// tb/tb_switch_input_buffer.sv - randomized bench for switch_input_buffer against a queue model
module tb_switch_input_buffer;

  localparam int FW    = 80;
  localparam int DEPTH = 4;
  localparam int N_OUT = 3;
  localparam int SLACK = 1;

  localparam logic [2:0] HEAD = 3'd1;
  localparam logic [2:0] PAYL = 3'd2;
  localparam logic [2:0] TAIL = 3'd3;
  localparam logic [2:0] SING = 3'd4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [FW-1:0]    flit_in = '0;
  logic             valid_in = 1'b0;
  logic             busy_out;
  logic [FW-1:0]    flit_out;
  logic             valid_out;
  logic [N_OUT-1:0] nack_in = '0;
  logic             overflow_err;
  logic             proto_err;

  int errors = 0;
  int checks = 0;

  logic [FW-1:0] q[$];
  logic          m_busy, m_ovf, m_perr, m_in_pkt;

  always #5 clk = ~clk;

  switch_input_buffer #(
    .FLIT_WIDTH(FW), .DEPTH(DEPTH), .N_OUT(N_OUT), .SLACK(SLACK)
  ) dut (
    .clk(clk), .rst(rst),
    .FLIT_in(flit_in), .VALID_in(valid_in), .BUSY_out(busy_out),
    .FLIT_out(flit_out), .VALID_out(valid_out), .NACK_in(nack_in),
    .overflow_err(overflow_err), .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mkf(input logic [2:0] t);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return {r[FW-1:3], t};
  endfunction

  // Model reacts to the inputs as they will be sampled at the next edge.
  task automatic step(input logic r, input logic v, input logic [FW-1:0] f, input logic [N_OUT-1:0] n);
    logic do_pop, do_push;
    rst = r; valid_in = v; flit_in = f; nack_in = n;
    if (r) begin
      q.delete();
      m_busy = 0; m_ovf = 0; m_perr = 0; m_in_pkt = 0;
    end else begin
      do_pop  = (q.size() > 0) && (n == '0);
      do_push = v && ((q.size() < DEPTH) || do_pop);
      if (v && !do_push) m_ovf = 1;
      if (do_push) begin
        case (f[2:0])
          HEAD: begin if (m_in_pkt) m_perr = 1; m_in_pkt = 1; end
          PAYL: if (!m_in_pkt) m_perr = 1;
          TAIL: begin if (!m_in_pkt) m_perr = 1; m_in_pkt = 0; end
          SING: begin if (m_in_pkt) m_perr = 1; m_in_pkt = 0; end
          default: m_perr = 1;
        endcase
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(f);
      m_busy = (q.size() >= DEPTH - SLACK);
    end
    @(posedge clk);
    @(negedge clk);
    check("valid_out", FW'(valid_out), FW'(q.size() != 0));
    check("busy_out", FW'(busy_out), FW'(m_busy));
    check("overflow_err", FW'(overflow_err), FW'(m_ovf));
    check("proto_err", FW'(proto_err), FW'(m_perr));
    if (q.size() != 0) check("flit_out", flit_out, q[0]);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, '0, '0);
  endtask

  initial begin
    logic [2:0] types [8];
    types = '{HEAD, PAYL, TAIL, SING, HEAD, PAYL, 3'd0, 3'd7};

    step(1, 0, '0, '0);
    step(1, 0, '0, '0);

    // single flit, popped the cycle after it appears
    step(0, 1, mkf(SING), '0);
    step(0, 0, '0, '0);

    // fill with NACKs held, overflow on the fifth, then full push+pop
    for (int i = 0; i < 5; i++) step(0, 1, mkf(i == 0 ? HEAD : PAYL), 3'b111);
    step(0, 1, mkf(TAIL), 3'b000);
    drain();
    step(1, 0, '0, '0);

    // packet with a NACK on alternating cycles
    for (int i = 0; i < 10; i++)
      step(0, i < 4, mkf(i == 0 ? HEAD : (i == 3 ? TAIL : PAYL)), i[0] ? 3'b010 : 3'b000);

    // framing errors still forwarded
    step(0, 1, mkf(PAYL), '0);
    step(0, 1, mkf(HEAD), '0);
    step(0, 1, mkf(HEAD), '0);
    drain();
    step(1, 0, '0, '0);

    // reset mid-packet with flits stored
    for (int i = 0; i < 3; i++) step(0, 1, mkf(i == 0 ? HEAD : PAYL), 3'b111);
    step(1, 0, '0, 3'b111);
    step(0, 1, mkf(SING), 3'b111);
    drain();

    for (int i = 0; i < 3000; i++) begin
      logic [N_OUT-1:0] n;
      n = ($urandom_range(0, 1) == 0) ? '0 : N_OUT'($urandom);
      if ($urandom_range(0, 99) == 0)
        step(1, 0, '0, '0);
      else if ($urandom_range(0, 9) < 8)
        step(0, $urandom_range(0, 2) != 0, mkf(types[$urandom_range(0, 5)]), n);
      else
        step(0, $urandom_range(0, 1) != 0, mkf(types[$urandom_range(0, 7)]), n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
